sha256_compress_ctrl: RTL and testbench
=======================================

Name: sha256_compress_ctrl

Overview:
Sequencer for the SHA-256 compression function. It accepts one pre-padded 512-bit message block per handshake and runs 64 rounds, one per cycle. Each round drives the shared choose primitive (prim_generic_ch) plus the Maj and Σ logic. At the end it folds the working variables into the chaining value. It sits between the hash front-end (padding and length insertion, out of scope) and the digest output register interface.

Parameters:
NumRounds, 64, rounds per block; 64 for SHA-256; smaller values allowed only for debug and simulation
WordW, 32, word width; fixed at 32; localparam-checked by assertion

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
init_i  in  1  reload chaining value H0..H7 with the SHA-256 IV
block_valid_i  in  1  block_i holds a valid padded block
block_ready_o  out  1  controller can accept a block
block_i  in  512  message block; word W0 = block_i[511:480], big-endian
busy_o  out  1  compression in progress
round_o  out  6  current round index t (0..NumRounds-1); 0 when idle
digest_valid_o  out  1  one-cycle pulse: digest_o updated for the last accepted block
digest_o  out  256  chaining value H0..H7; H0 = digest_o[255:224]

Behaviour:
- Reset values (async, rst_ni low):
  - state = IDLE; H = IV (6a09e667 … 5be0cd19); a..h = 0; W window = 0; round counter = 0.
  - block_ready_o = 1, busy_o = 0, digest_valid_o = 0, round_o = 0, digest_o = IV.
- FSM states:
  - IDLE: block_ready_o = 1. A transfer occurs on block_valid_i & block_ready_o. On transfer: latch W[0..15] from block_i, load a..h ← H, counter ← 0, go to ROUND.
  - ROUND: one round per cycle, t = counter.
    - W_t = window[0] for every t. Window shifts each round; the new entry is σ1(W[14]) + σ0(W[1]) + W[9] + W[0].
    - T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t.
    - T2 = Σ0(a) + Maj(a,b,c).
    - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
    - All additions are mod 2^32; carries are discarded.
    - Leave ROUND when t = NumRounds-1, going to FINAL.
  - FINAL: Hi ← Hi + working var i (mod 2^32); digest_valid_o = 1 this cycle; go to IDLE.
- Outputs and latency:
  - busy_o = (state != IDLE). block_ready_o = (state == IDLE), combinational from state.
  - Ch(e,f,g) comes from a prim_generic_ch instance with Width = 32.
  - Transfer in cycle N: rounds occupy N+1..N+64, digest_valid_o is high in N+65, and block_ready_o is high again in N+66.
  - Minimum accept-to-accept spacing is 66 cycles.
  - digest_o reflects the registered H and is stable outside FINAL+1.
- Chaining: H persists across blocks, so multi-block messages need no init_i between blocks.
- init_i:
  - Honoured only in IDLE; ignored while busy, with no effect on an in-flight block.
  - init_i together with a block transfer in the same IDLE cycle: IV is used as the starting H for that block.
  - init_i does not pulse digest_valid_o; digest_o shows IV from the next cycle.
- block_valid_i while busy: no transfer. block_i is sampled only on the transfer cycle and may change afterwards.
- Reset mid-operation: immediate abort, all state returns to reset values, and no digest_valid_o pulse.
- round_o = counter in ROUND, 0 otherwise.
- Assertions:
  - digest_valid_o is never high on two consecutive cycles.
  - No transfer occurs while busy_o.

Decomposition:
- Package sha256_pkg:
  - K[0:63] constant array and IV[0:7].
  - state_e enum {IDLE, ROUND, FINAL}.
  - Functions big_sigma0/1, small_sigma0/1 and maj, operating on 32-bit words.
  - word_t typedef (logic [31:0]).
- Sub-module sha256_msg_sched: owns the 16-word W window.
  - Inputs: load_i, shift_i, block_i.
  - Output: w_o = current W_t.
- The controller keeps the FSM, counter, working variables and H.

Test Plan:
- "abc": init_i, then block 61626380 00000000 … 00000018 → digest_valid_o at accept+65, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: block 80000000, 14 zero words, then 00000000 (length word) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Feed both blocks back-to-back with valid held high.
  - Second block accepted exactly 66 cycles after the first; final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - digest_valid_o pulses twice.
- Busy rules:
  - block_valid_i and init_i toggled during ROUND → no extra transfers, round_o counts 0..63 monotonically, "abc" digest unchanged.
  - Second "abc" without init_i → digest differs from ba7816bf…; with init_i → matches.
- Reset mid-operation:
  - Assert rst_ni low at round 30 → busy_o = 0, block_ready_o = 1, digest_o = IV, no digest_valid_o pulse.
  - A subsequent "abc" block yields the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, state encoding and word-level helper functions
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_e;

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/prim_generic_ch.sv
// prim_generic_ch: bitwise choose, each bit of x selects y (1) or z (0)
module prim_generic_ch #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic [Width-1:0] z_i,
    output logic [Width-1:0] ch_o
);

    assign ch_o = (x_i & y_i) ^ (~x_i & z_i);

endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word sliding message-schedule window, W_t always at slot 0
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [511:0] block_i,
    output word_t        w_o
);

    word_t w [16];
    word_t w_new;

    // next schedule word W[t+16] from the current window
    always_comb begin
        w_new = small_sigma1(w[14]) + small_sigma0(w[1]) + w[9] + w[0];
    end

    // load the block big-endian on transfer, otherwise slide one word per round
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < 16; i++) w[i] <= block_i[511-32*i -: 32];
        end else if (shift_i) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
        end
    end

    assign w_o = w[0];

endmodule

// File: rtl/sha256_compress_ctrl.sv
// sha256_compress_ctrl: one-round-per-cycle SHA-256 compression sequencer with chaining value
module sha256_compress_ctrl
    import sha256_pkg::*;
#(
    parameter int NumRounds = 64,
    parameter int WordW     = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         init_i,
    input  logic         block_valid_i,
    output logic         block_ready_o,
    input  logic [511:0] block_i,
    output logic         busy_o,
    output logic [5:0]   round_o,
    output logic         digest_valid_o,
    output logic [255:0] digest_o
);

    state_e     state;
    logic [5:0] cnt;
    word_t      hv [8];
    word_t      wv [8];
    word_t      w_t, ch, t1, t2;
    logic       xfer, last;

    assign block_ready_o = state == IDLE;
    assign busy_o        = state != IDLE;
    assign xfer          = block_valid_i & block_ready_o;
    assign last          = cnt == 6'(NumRounds - 1);
    assign round_o       = state == ROUND ? cnt : '0;
    assign digest_o      = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};

    prim_generic_ch #(.Width(32)) u_ch (
        .x_i  (wv[4]),
        .y_i  (wv[5]),
        .z_i  (wv[6]),
        .ch_o (ch)
    );

    sha256_msg_sched u_sched (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (xfer),
        .shift_i (state == ROUND),
        .block_i (block_i),
        .w_o     (w_t)
    );

    // round temporaries; wv[0..7] hold a..h
    always_comb begin
        t1 = wv[7] + big_sigma1(wv[4]) + ch + K[cnt] + w_t;
        t2 = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    end

    // sequencer: accept block, run rounds, fold working variables into H
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            cnt            <= '0;
            digest_valid_o <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= IV[i];
                wv[i] <= '0;
            end
        end else begin
            digest_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_i) for (int i = 0; i < 8; i++) hv[i] <= IV[i];
                    if (xfer) begin
                        for (int i = 0; i < 8; i++) wv[i] <= init_i ? IV[i] : hv[i];
                        cnt   <= '0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    wv[0] <= t1 + t2;
                    wv[1] <= wv[0];
                    wv[2] <= wv[1];
                    wv[3] <= wv[2];
                    wv[4] <= wv[3] + t1;
                    wv[5] <= wv[4];
                    wv[6] <= wv[5];
                    wv[7] <= wv[6];
                    cnt   <= cnt + 6'd1;
                    if (last) begin
                        state          <= FINAL;
                        digest_valid_o <= 1'b1;
                    end
                end
                default: begin
                    for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    a_word_width: assert property (@(posedge clk_i) WordW == 32);
    a_num_rounds: assert property (@(posedge clk_i) NumRounds >= 1 && NumRounds <= 64);
    a_dv_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        digest_valid_o |=> !digest_valid_o);
    a_no_busy_xfer: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(xfer && busy_o));

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// tb_sha256_compress_ctrl: directed known-answer and protocol checks for the compression sequencer
module tb_sha256_compress_ctrl;

    localparam logic [255:0] IVD  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DEMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] BABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BEMP = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B2A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2B  = {{15{32'h0}}, 32'h000001c0};

    logic         clk, rst_n, init, bv, br, busy, dv;
    logic [511:0] blk;
    logic [5:0]   round;
    logic [255:0] dig;
    int           cyc, dv_cnt, total, bad;

    sha256_compress_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .init_i         (init),
        .block_valid_i  (bv),
        .block_ready_o  (br),
        .block_i        (blk),
        .busy_o         (busy),
        .round_o        (round),
        .digest_valid_o (dv),
        .digest_o       (dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (dv === 1'b1) dv_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [255:0] obs, input logic [255:0] avoid);
        total++;
        assert (obs !== avoid) else begin
            bad++;
            $error("FAIL %s: got %h want anything but %h", tag, obs, avoid);
        end
    endtask

    task automatic wait_dv(output int n);
        n = 1;
        while (dv !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_block(input string tag, input logic [511:0] b, input logic ini,
                             input logic [255:0] exp, input logic expect_eq);
        int n, d0;
        d0 = dv_cnt;
        chk({tag, " ready"}, 256'(br), 256'(1));
        blk  = b;
        bv   = 1'b1;
        init = ini;
        @(negedge clk);
        bv   = 1'b0;
        init = 1'b0;
        blk  = {16{32'hdeadbeef}};
        wait_dv(n);
        chk({tag, " latency"}, 256'(n), 256'(65));
        @(negedge clk);
        if (expect_eq) chk({tag, " digest"}, dig, exp);
        else chk_ne({tag, " digest"}, dig, exp);
        chk({tag, " ready_after"}, 256'({br, busy}), 256'(2'b10));
        chk({tag, " pulses"}, 256'(dv_cnt - d0), 256'(1));
    endtask

    initial begin
        int n, d0;
        logic rok;
        total = 0; bad = 0; cyc = 0; dv_cnt = 0;
        rst_n = 1'b0; init = 1'b0; bv = 1'b0; blk = '0;
        repeat (3) @(negedge clk);
        chk("reset ctrl", 256'({br, busy, dv, round}), 256'({1'b1, 1'b0, 1'b0, 6'd0}));
        chk("reset digest", dig, IVD);
        rst_n = 1'b1;
        @(negedge clk);

        run_block("abc", BABC, 1'b1, DABC, 1'b1);
        run_block("empty", BEMP, 1'b1, DEMP, 1'b1);

        d0   = dv_cnt;
        blk  = B2A;
        bv   = 1'b1;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        blk  = B2B;
        n = 1;
        while (br !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("two spacing", 256'(n), 256'(66));
        chk_ne("two mid digest", dig, IVD);
        @(negedge clk);
        bv = 1'b0;
        wait_dv(n);
        chk("two latency", 256'(n), 256'(65));
        @(negedge clk);
        chk("two digest", dig, D2B);
        chk("two pulses", 256'(dv_cnt - d0), 256'(2));

        d0   = dv_cnt;
        rok  = 1'b1;
        blk  = BABC;
        bv   = 1'b1;
        init = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (round !== 6'(i) || br !== 1'b0) rok = 1'b0;
            bv   = 1'($urandom);
            init = 1'($urandom);
            for (int k = 0; k < 16; k++) blk[k*32 +: 32] = $urandom;
        end
        @(negedge clk);
        bv   = 1'b0;
        init = 1'b0;
        chk("busy rounds", 256'(rok), 256'(1));
        chk("busy dv", 256'(dv), 256'(1));
        @(negedge clk);
        chk("busy digest", dig, DABC);
        chk("busy pulses", 256'(dv_cnt - d0), 256'(1));

        run_block("abc chained", BABC, 1'b0, DABC, 1'b0);

        d0   = dv_cnt;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("init digest", dig, IVD);
        @(negedge clk);
        chk("init no pulse", 256'(dv_cnt - d0), 256'(0));

        run_block("abc reinit", BABC, 1'b1, DABC, 1'b1);

        d0  = dv_cnt;
        blk = BABC;
        bv  = 1'b1;
        @(negedge clk);
        bv = 1'b0;
        n  = 0;
        while (round !== 6'd30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached r30", 256'(round), 256'(30));
        rst_n = 1'b0;
        #1;
        chk("abort ctrl", 256'({br, busy, dv, round}), 256'({1'b1, 1'b0, 1'b0, 6'd0}));
        chk("abort digest", dig, IVD);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("abort no pulse", 256'(dv_cnt - d0), 256'(0));
        chk("abort idle", 256'({br, busy}), 256'(2'b10));

        run_block("abc after abort", BABC, 1'b0, DABC, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
